load_store_unit: RTL
====================

# load_store_unit

Initiator side of the data-memory port: accepts single load/store requests from the core datapath and drives the word-organised data memory's address, MemRead, MemWrite and write_data. It performs byte/halfword extraction with sign or zero extension, and read-modify-write for sub-word stores. It sits between the execute stage and the data memory and handles one transaction at a time.

## Interface
- W, 32, data and address width
- N, 5, memory depth exponent (2**N words)

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  unit idle, request accepted on clk edge when req_valid && req_ready
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend
- req_addr  in  W  byte address
- req_wdata  in  W  store data, low-aligned (byte in [7:0], half in [15:0])
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  W  load result, 0 for stores and errors
- resp_error  out  1  qualifies resp_valid
- mem_address  out  W  word index = req_addr >> 2
- MemRead  out  1  memory read strobe
- MemWrite  out  1  memory write strobe
- write_data  out  W  word to store
- read_data  in  W  memory read data, valid the cycle after MemRead

## Operation
- States: IDLE, RD, RDW, WR, RESP. Request fields are latched on accept.
- Error check at accept: error if req_size==11 or req_addr[W-1:N+2]!=0. Misalignment is also an error when the macro is enabled. Error path: IDLE->RESP with resp_error=1 and resp_rdata=0, and no memory strobe.
- Word store: IDLE->WR->RESP. WR asserts MemWrite with write_data=req_wdata.
- Load: IDLE->RD->RDW->RESP. RD asserts MemRead. RDW samples read_data and extracts the addressed lane into resp_rdata.
- Sub-word store: IDLE->RD->RDW->WR->RESP. RDW merges req_wdata into the addressed lane of read_data and registers the result. WR writes the merged word.
- Lanes are little-endian. Byte lane = req_addr[1:0]. Half lane = req_addr[1] (bits [15:0] or [31:16]). Extension uses the lane MSB unless req_unsigned=1.
- RESP always returns to IDLE. There is no response backpressure.
- Invariants:
  - MemRead and MemWrite are never high together.
  - Each is high for exactly one cycle per transaction.
  - mem_address is held constant from RD/WR entry until RESP.
- req_ready = state==IDLE, gated low until the first clk edge after rst deasserts.

## Timing
- Accept edge = edge 0.
- Word store: MemWrite high in cycle 1, resp_valid in cycle 2.
- Load: MemRead high in cycle 1, resp_valid with resp_rdata in cycle 3.
- Sub-word store: MemRead cycle 1, MemWrite cycle 3, resp_valid cycle 4.
- Error: resp_valid and resp_error in cycle 1.
- The next request can be accepted on the edge ending RESP+1 (IDLE cycle). Throughput is one transaction per latency+1 cycles.
- Reset values: req_ready=0, resp_valid=0, resp_rdata=0, resp_error=0, mem_address=0, MemRead=0, MemWrite=0, write_data=0, state=IDLE.
- Reset mid-operation: strobes drop immediately (asynchronous), the transaction is discarded, no response is issued, and no memory write occurs.
- req_valid while busy is ignored, with req_ready=0. Requests are never queued.

## Configuration
- LSU_MISALIGN_TRAP_EN defined: a half with req_addr[0]=1, or a word with req_addr[1:0]!=0, completes via the error path with no memory access.
- Undefined: misalignment is never an error. Halves ignore req_addr[0]. Words ignore req_addr[1:0]. The access uses the aligned lane.

## Test plan
- Word store 0xDEADBEEF at 0x10, then word load 0x10.
  - Store: MemWrite in cycle 1 with mem_address=4 and write_data=0xDEADBEEF.
  - Load: resp_rdata=0xDEADBEEF with resp_valid at cycle 3.
- Byte store 0x5A at 0x11 over 0xDEADBEEF.
  - RMW: MemRead cycle 1, MemWrite cycle 3 with write_data=0xDEAD5AEF, resp_valid cycle 4.
- Loads from word 0xDEAD5AEF:
  - Signed byte load at 0x13 returns 0xFFFFFFDE.
  - Unsigned byte load at 0x13 returns 0x000000DE.
  - Signed half load at 0x12 returns 0xFFFFDEAD.
- Load at 0x80 with N=5: resp_error=1 and resp_rdata=0 in cycle 1, no MemRead or MemWrite. Repeat with req_size=11: same result.
- Word load at 0x13:
  - With LSU_MISALIGN_TRAP_EN: error in cycle 1.
  - Without it: returns 0xDEAD5AEF at cycle 3.
- rst low during RDW of a byte store: MemWrite never asserts, resp_valid stays 0, and a subsequent load returns the prior word. req_ready=1 from the first edge after release.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store initiator for a word-organised
// data memory. Performs byte/half extraction with sign/zero extension on loads
// and read-modify-write on sub-word stores.
//
// Optional feature: define LSU_MISALIGN_TRAP_EN to report misaligned halves and
// words as errors; otherwise the low address bits are ignored and the aligned
// lane is accessed.
//
// Ports:
//   clk, rst (async, active-low)
//   req_*       : request handshake and fields (accepted on req_valid && req_ready)
//   resp_*      : one-cycle completion pulse with load data and error flag
//   mem_address : word index, MemRead/MemWrite strobes, write_data to memory
//   read_data   : memory data, valid the cycle after MemRead
module load_store_unit #(
    parameter int W = 32,
    parameter int N = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_write,
    input  logic [1:0]   req_size,
    input  logic         req_unsigned,
    input  logic [W-1:0] req_addr,
    input  logic [W-1:0] req_wdata,
    output logic         resp_valid,
    output logic [W-1:0] resp_rdata,
    output logic         resp_error,
    output logic [W-1:0] mem_address,
    output logic         MemRead,
    output logic         MemWrite,
    output logic [W-1:0] write_data,
    input  logic [W-1:0] read_data
);

    typedef enum logic [2:0] {IDLE, RD, RDW, WR, RESP} state_t;

    state_t     state, state_nxt;
    logic       rdy_en;
    logic       wr_q, uns_q;
    logic [1:0] size_q;
    logic [1:0] lo_q;
    logic       accept, err;
    logic [W-1:0] merged, extracted;
    logic [7:0]   rd_byte;
    logic [15:0]  rd_half;

    // req_ready stays low until the first edge after reset release.
    assign req_ready = (state == IDLE) && rdy_en;
    assign accept    = req_valid && req_ready;

    always_comb begin
        err = (req_size == 2'b11) || (|req_addr[W-1:N+2]);
`ifdef LSU_MISALIGN_TRAP_EN
        if ((req_size == 2'b01 && req_addr[0]) || (req_size == 2'b10 && |req_addr[1:0]))
            err = 1'b1;
`endif
    end

    // Strobes and response pulse decode straight from state, so an async reset
    // drops them immediately.
    assign MemRead    = (state == RD);
    assign MemWrite   = (state == WR);
    assign resp_valid = (state == RESP);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            rdy_en <= 1'b0;
        end else begin
            state  <= state_nxt;
            rdy_en <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) begin
                if (err)                              state_nxt = RESP;
                else if (req_write && req_size == 2'b10) state_nxt = WR;
                else                                  state_nxt = RD;
            end
            RD:   state_nxt = RDW;
            RDW:  state_nxt = wr_q ? WR : RESP;
            WR:   state_nxt = RESP;
            RESP: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Lane select: halves use addr[1] only, so an unaligned half (macro off)
    // falls onto its aligned lane.
    always_comb begin
        rd_byte   = read_data[{lo_q, 3'b000} +: 8];
        rd_half   = read_data[{lo_q[1], 4'b0000} +: 16];
        extracted = read_data;
        case (size_q)
            2'b00: extracted = uns_q ? {{(W-8){1'b0}}, rd_byte}
                                     : {{(W-8){rd_byte[7]}}, rd_byte};
            2'b01: extracted = uns_q ? {{(W-16){1'b0}}, rd_half}
                                     : {{(W-16){rd_half[15]}}, rd_half};
            default: extracted = read_data;
        endcase
    end

    // write_data holds the raw store data from accept until RDW replaces it
    // with the merged word.
    always_comb begin
        merged = read_data;
        case (size_q)
            2'b00:   merged[{lo_q, 3'b000} +: 8]     = write_data[7:0];
            2'b01:   merged[{lo_q[1], 4'b0000} +: 16] = write_data[15:0];
            default: merged = write_data;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q        <= 1'b0;
            uns_q       <= 1'b0;
            size_q      <= 2'b00;
            lo_q        <= 2'b00;
            mem_address <= '0;
            write_data  <= '0;
            resp_rdata  <= '0;
            resp_error  <= 1'b0;
        end else if (accept) begin
            wr_q        <= req_write;
            uns_q       <= req_unsigned;
            size_q      <= req_size;
            lo_q        <= req_addr[1:0];
            mem_address <= {2'b00, req_addr[W-1:2]};
            write_data  <= req_wdata;
            resp_rdata  <= '0;
            resp_error  <= err;
        end else if (state == RDW) begin
            if (wr_q) write_data <= merged;
            else      resp_rdata <= extracted;
        end
    end

endmodule
